// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send, clocks one
// command byte out on device-generated clock edges and checks the device ACK.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 3000,
  parameter int unsigned START_SETUP    = 25,
  parameter int unsigned TIMEOUT_CYCLES = 375000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err,
  output logic [1:0] o_err_code,
  input  logic       i_ps2clk,
  input  logic       i_ps2data,
  output logic       o_ps2clk_oe,
  output logic       o_ps2data_oe
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_SEND      = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  localparam logic [18:0] L_INHIBIT_LAST = 19'(INHIBIT_CYCLES - 1);
  localparam logic [18:0] L_SETUP_LAST   = 19'(START_SETUP - 1);
  localparam logic [18:0] L_TIMEOUT_LAST = 19'(TIMEOUT_CYCLES - 1);

  logic [2:0]  r_state;
  logic [18:0] r_cnt;
  logic [7:0]  r_sr;
  logic [9:0]  r_frame;
  logic [3:0]  r_bitcnt;
  logic        r_data_oe;
  logic        r_done;
  logic        r_err;
  logic [1:0]  r_err_code;

  logic w_fe;
  logic w_tx_ready;
  logic w_accept;
  logic w_timeout;

  // Glitch-filtered falling edge: four high samples followed by four low samples.
  assign w_fe       = (r_sr[7:4] == 4'hF) && (r_sr[3:0] == 4'h0);
  // Not ready during a done/err pulse so a new request lands the cycle after it.
  assign w_tx_ready = (r_state == S_IDLE) && !r_done && !r_err;
  assign w_accept   = i_tx_valid && w_tx_ready;
  assign w_timeout  = (r_cnt == L_TIMEOUT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sr       <= '0;
      r_frame    <= '0;
      r_bitcnt   <= '0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_sr   <= {r_sr[6:0], i_ps2clk};
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_frame <= {1'b1, ~^i_tx_data, i_tx_data};
            r_cnt   <= '0;
            r_state <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_cnt == L_INHIBIT_LAST) begin
            r_cnt     <= '0;
            r_data_oe <= 1'b1;
            r_state   <= S_START;
          end else begin
            r_cnt <= r_cnt + 19'd1;
          end
        end
        S_START: begin
          if (r_cnt == L_SETUP_LAST) begin
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_state  <= S_SEND;
          end else begin
            r_cnt <= r_cnt + 19'd1;
          end
        end
        S_SEND: begin
          if (w_fe) begin
            r_cnt     <= '0;
            r_data_oe <= ~r_frame[r_bitcnt];
            r_bitcnt  <= r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd9) r_state <= S_ACK;
          end else if (w_timeout) begin
            r_data_oe  <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= 2'b01;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 19'd1;
          end
        end
        S_ACK: begin
          if (w_fe) begin
            r_cnt <= '0;
            if (!i_ps2data) begin
              r_state <= S_WAIT_IDLE;
            end else begin
              r_data_oe  <= 1'b0;
              r_err      <= 1'b1;
              r_err_code <= 2'b10;
              r_state    <= S_IDLE;
            end
          end else if (w_timeout) begin
            r_data_oe  <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= 2'b01;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 19'd1;
          end
        end
        S_WAIT_IDLE: begin
          if (i_ps2clk && i_ps2data) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_fe) begin
            r_cnt <= '0;
          end else if (w_timeout) begin
            r_data_oe  <= 1'b0;
            r_err      <= 1'b1;
            r_err_code <= 2'b01;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 19'd1;
          end
        end
        default: begin
          r_data_oe <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tx_ready   = w_tx_ready;
  assign o_busy       = ~w_tx_ready;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_err_code   = r_err_code;
  assign o_ps2clk_oe  = (r_state == S_INHIBIT) || (r_state == S_START);
  assign o_ps2data_oe = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the DUT and the
// observed line bits, pulses and phase lengths are compared to a reference model.
module tb_ps2_host_tx;

  localparam int unsigned INH   = 300;
  localparam int unsigned SETUP = 25;
  localparam int unsigned TMO   = 2000;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, busy, done, err;
  logic [1:0] err_code;
  logic       ps2clk_in, ps2data_in, ps2clk_oe, ps2data_oe;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;

  always #5 clk = ~clk;

  // Open-drain bus with pull-ups: low if either side drives.
  assign ps2clk_in  = ~ps2clk_oe & dev_clk;
  assign ps2data_in = ~ps2data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_SETUP   (SETUP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_tx_data   (tx_data),
    .i_tx_valid  (tx_valid),
    .o_tx_ready  (tx_ready),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_err_code  (err_code),
    .i_ps2clk    (ps2clk_in),
    .i_ps2data   (ps2data_in),
    .o_ps2clk_oe (ps2clk_oe),
    .o_ps2data_oe(ps2data_oe)
  );

  typedef struct {
    logic [7:0] data;
    bit         ack;
    logic [9:0] exp_frame;
    bit         exp_done;
    logic [1:0] exp_code;
  } vec_t;

  vec_t tbl[5];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done, n_err, n_both, n_inh, n_setup, n_rdybad;
  int t_rel, t_err;
  logic [1:0] last_code;
  bit prev_err, rdy_at_err, rdy_after_err, oe_at_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: data LSB first, odd parity, stop bit.
  function automatic logic [9:0] model_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (prev_err) rdy_after_err = tx_ready;
    prev_err = err;
    if (done) n_done++;
    if (err) begin
      n_err++;
      last_code  = err_code;
      rdy_at_err = tx_ready;
      oe_at_err  = ps2clk_oe | ps2data_oe;
      t_err      = cyc;
    end
    if (done && err) n_both++;
    if (busy == tx_ready) n_rdybad++;
    if (ps2clk_oe && !ps2data_oe) n_inh++;
    if (ps2clk_oe && ps2data_oe) n_setup++;
  endtask

  task automatic clear_stats();
    n_done = 0; n_err = 0; n_both = 0; n_inh = 0; n_setup = 0; n_rdybad = 0;
    rdy_at_err = 1'b0; rdy_after_err = 1'b0; oe_at_err = 1'b0; t_err = 0;
  endtask

  task automatic send_req(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 200) begin step(); n++; end
    check("ready_before_req", tx_ready, 1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    clear_stats();
    step();
    tx_valid = 1'b0;
  endtask

  task automatic dev_run(input int nfalls, input bit ack, input int half,
                         output logic [9:0] seen);
    int n;
    seen = '0;
    n = 0;
    while (!ps2clk_oe && n < 20) begin step(); n++; end
    check("inhibit_start", ps2clk_oe, 1'b1);
    n = 0;
    while (ps2clk_oe && n < int'(INH + SETUP) + 20) begin step(); n++; end
    check("clk_release", ps2clk_oe, 1'b0);
    t_rel = cyc;
    repeat (half) step();
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 11 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (half) step();
      dev_clk = 1'b1;
      if (k <= 10) seen[k-1] = ps2data_in;
      if (k == 11) dev_data = 1'b1;
      repeat (half) step();
    end
  endtask

  task automatic wait_end(input int bound);
    int n = 0;
    while ((n_done + n_err) == 0 && n < bound) begin step(); n++; end
    if ((n_done + n_err) == 0) begin
      checks++;
      errors++;
      $display("FAIL end_of_transfer: no done/err within %0d cycles", bound);
    end
    step();
    step();
  endtask

  task automatic run_frame(input vec_t v, input int half, input string tag);
    logic [9:0] seen;
    send_req(v.data);
    dev_run(11, v.ack, half, seen);
    wait_end(4 * half + 100);
    check({tag, "_frame"}, seen, v.exp_frame);
    check({tag, "_done"}, n_done, v.exp_done ? 1 : 0);
    check({tag, "_err"}, n_err, v.exp_done ? 0 : 1);
    check({tag, "_inhibit"}, n_inh, INH);
    check({tag, "_setup"}, n_setup, SETUP);
    check({tag, "_done_err_overlap"}, n_both, 0);
    check({tag, "_busy_ready"}, n_rdybad, 0);
    if (!v.exp_done) begin
      check({tag, "_err_code"}, last_code, v.exp_code);
      check({tag, "_ready_at_err"}, rdy_at_err, 1'b0);
      check({tag, "_ready_after_err"}, rdy_after_err, 1'b1);
    end
  endtask

  initial begin
    logic [9:0] seen;
    vec_t v;
    int   n;

    tbl[0] = '{data: 8'hED, ack: 1'b1, exp_frame: 10'h3ED, exp_done: 1'b1, exp_code: 2'b00};
    tbl[1] = '{data: 8'hF4, ack: 1'b1, exp_frame: 10'h2F4, exp_done: 1'b1, exp_code: 2'b00};
    tbl[2] = '{data: 8'hA5, ack: 1'b0, exp_frame: 10'h3A5, exp_done: 1'b0, exp_code: 2'b10};
    tbl[3] = '{data: 8'h00, ack: 1'b1, exp_frame: 10'h300, exp_done: 1'b1, exp_code: 2'b00};
    tbl[4] = '{data: 8'h81, ack: 1'b1, exp_frame: 10'h381, exp_done: 1'b1, exp_code: 2'b00};

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    clear_stats();
    repeat (3) step();
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_err_code", err_code, 2'b00);
    check("rst_clk_oe", ps2clk_oe, 1'b0);
    check("rst_data_oe", ps2data_oe, 1'b0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_frame(tbl[i], 20, $sformatf("tbl%0d", i));

    // Device never clocks after release.
    send_req(8'h5A);
    dev_run(0, 1'b0, 10, seen);
    n = 0;
    while (n_err == 0 && n < int'(TMO) + 50) begin step(); n++; end
    step();
    step();
    check("tmo_err", n_err, 1);
    check("tmo_latency", t_err - t_rel, TMO);
    check("tmo_code", last_code, 2'b01);
    check("tmo_oe_released", oe_at_err, 1'b0);
    check("tmo_ready_at_err", rdy_at_err, 1'b0);
    check("tmo_ready_after", rdy_after_err, 1'b1);
    check("tmo_no_done", n_done, 0);

    // Reset in the middle of the data bits.
    send_req(8'h00);
    dev_run(4, 1'b0, 20, seen);
    check("midrst_pre_data_oe", ps2data_oe, 1'b1);
    reset = 1'b1;
    step();
    check("midrst_clk_oe", ps2clk_oe, 1'b0);
    check("midrst_data_oe", ps2data_oe, 1'b0);
    check("midrst_ready", tx_ready, 1'b1);
    check("midrst_no_pulse", done | err, 1'b0);
    reset = 1'b0;
    step();
    v = '{data: 8'hFF, ack: 1'b1, exp_frame: model_frame(8'hFF), exp_done: 1'b1, exp_code: 2'b00};
    run_frame(v, 20, "after_rst");

    // Second request while busy must not disturb the frame in flight.
    send_req(8'hED);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    dev_run(11, 1'b1, 20, seen);
    wait_end(200);
    check("busy_req_frame", seen, model_frame(8'hED));
    check("busy_req_done", n_done, 1);
    repeat (20) step();
    check("busy_req_no_restart", ps2clk_oe, 1'b0);
    check("busy_req_idle", tx_ready, 1'b1);

    // Randomised frames against the reference model.
    for (int i = 0; i < 6; i++) begin
      v.data      = 8'($urandom_range(0, 255));
      v.ack       = ($urandom_range(0, 3) != 0);
      v.exp_frame = model_frame(v.data);
      v.exp_done  = v.ack;
      v.exp_code  = v.ack ? 2'b00 : 2'b10;
      run_frame(v, int'($urandom_range(12, 40)), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
